pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline control unit for the five-stage MIPS core: merges per-stage stall requests into the 6-bit `stall` vector consumed by every pipeline register (pc_reg, if_id, id_ex, ex_mem, mem_wb), and turns MEM-stage exceptions into a one-cycle `flush` plus redirect PC. Sits beside the datapath, driven by id, ex, mem, the bus interfaces and cp0. It adds a pending-exception state so an exception raised while a MEM bus access is in flight waits until the access completes. It also provides a saturating stall-duration counter with a sticky watchdog flag.

## Interface
- `EXC_VECTOR`, 32'h0000_0020, redirect target for all non-eret exceptions.
- `WDOG_LIMIT`, 16'd1024, consecutive stalled cycles that set `stall_timeout`.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `stallreq_if`  in  1  instruction bus not ready.
- `stallreq_id`  in  1  load-use hazard.
- `stallreq_ex`  in  1  multi-cycle madd/msub/div in progress.
- `stallreq_mem`  in  1  data bus access in flight.
- `excepttype_i`  in  32  MEM-stage exception code, 0 = none.
- `cp0_epc_i`  in  32  forwarded EPC value.
- `stall`  out  6  bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB; 1 = hold.
- `flush`  out  1  clear all pipeline registers this cycle.
- `new_pc`  out  32  redirect address, valid when `flush`=1.
- `stall_cnt`  out  16  current consecutive-stall length, saturating.
- `stall_timeout`  out  1  sticky, set when `stall_cnt` reaches `WDOG_LIMIT`.

## Operation
- Stall merge, highest priority first:
  - `stallreq_mem` -> 6'b011111.
  - `stallreq_ex` -> 6'b001111.
  - `stallreq_id` -> 6'b000111.
  - `stallreq_if` -> 6'b000111.
  - otherwise 6'b000000.
- Exception codes: 0x1 interrupt, 0x8 syscall, 0xa invalid instruction, 0xd trap, 0xc overflow, 0xe eret.
  - eret -> `new_pc`=EPC.
  - any other non-zero code -> `new_pc`=`EXC_VECTOR`.
- FSM states: IDLE, PEND.
- IDLE:
  - `excepttype_i`!=0 and `stallreq_mem`=0 -> `flush`=1, `stall`=0, `new_pc` from the live inputs; stay IDLE.
  - `excepttype_i`!=0 and `stallreq_mem`=1 -> capture code and `cp0_epc_i`; `stall`=6'b011111, `flush`=0; go to PEND.
  - otherwise apply the stall merge.
- PEND:
  - `excepttype_i` is ignored.
  - While `stallreq_mem`=1: `stall`=6'b011111, `flush`=0.
  - When `stallreq_mem`=0: `flush`=1, `stall`=0, `new_pc` from the captured code and EPC; return to IDLE.
- `flush` always forces `stall`=0. Only one flush is issued per exception.
- Stall counter:
  - Increments in each cycle where `stall`!=0 and `flush`=0.
  - Clears to 0 in any other cycle.
  - Saturates at 16'hFFFF.
  - `stall_timeout` is set in the cycle after `stall_cnt`==`WDOG_LIMIT`, and is cleared only by `rst`.

## Timing
- `stall`, `flush` and `new_pc` are combinational from inputs and state, with zero latency, so the pipeline registers act on them at the next edge.
- While `rst`=1 all outputs are forced to 0. On the first edge with `rst` high: state=IDLE, captured code/EPC=0, `stall_cnt`=0, `stall_timeout`=0.
- Reset asserted in PEND: return to IDLE with no flush issued; the captured exception is discarded.
- Exception and `stallreq_ex`/`stallreq_id`/`stallreq_if` in the same cycle with `stallreq_mem`=0: flush wins and the stall requests are ignored.
- A PEND -> IDLE flush cycle followed immediately by a new non-zero `excepttype_i` is handled as a fresh exception.
- `stall_cnt` is registered and reflects the stall length before the current cycle.

## Structure
- Shared package/define file holds:
  - exception codes (`EXC_INT`, `EXC_SYSCALL`, `EXC_INST_INVALID`, `EXC_TRAP`, `EXC_OV`, `EXC_ERET`);
  - stall vector constants (`STALL_NONE`, `STALL_ID`, `STALL_EX`, `STALL_MEM`);
  - the state encoding.
- Single module. The stall merge is a small combinational function; a sub-module is not needed.

## Test plan
- Priority: `stallreq_id`=1 alone -> `stall`=000111. Add `stallreq_mem`=1 -> 011111. Add `stallreq_ex` only -> 001111.
- Syscall, no bus: `excepttype_i`=0x8 for 1 cycle -> same cycle `flush`=1, `stall`=0, `new_pc`=0x20; next cycle `flush`=0.
- eret: `excepttype_i`=0xe, `cp0_epc_i`=0x1000 -> `flush`=1, `new_pc`=0x1000.
- Pending:
  - Set `excepttype_i`=0xc, `stallreq_mem`=1 for 3 cycles, with `excepttype_i` dropping to 0 after cycle 1 -> `stall`=011111 for 3 cycles, `flush`=0.
  - Then `stallreq_mem`=0 -> `flush`=1, `new_pc`=0x20, exactly one pulse.
- Reset in PEND: enter PEND, assert `rst` for 1 cycle -> no flush ever; state IDLE; `stall`=0 after release with no requests.
- Watchdog: `WDOG_LIMIT`=4, hold `stallreq_ex`=1 -> `stall_cnt` 0,1,2,3,4, `stall_timeout` rises next cycle and stays 1 after the request drops; `stall_cnt` returns to 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline control unit: exception codes, stall vectors, FSM encoding.
package pipe_ctrl_pkg;

    localparam logic [31:0] EXC_INT          = 32'h0000_0001;
    localparam logic [31:0] EXC_SYSCALL      = 32'h0000_0008;
    localparam logic [31:0] EXC_INST_INVALID = 32'h0000_000a;
    localparam logic [31:0] EXC_TRAP         = 32'h0000_000d;
    localparam logic [31:0] EXC_OV           = 32'h0000_000c;
    localparam logic [31:0] EXC_ERET         = 32'h0000_000e;

    // bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_e;

    function automatic logic [5:0] stall_merge(
        input logic req_if,
        input logic req_id,
        input logic req_ex,
        input logic req_mem
    );
        logic [5:0] s;
        if (req_mem)                 s = STALL_MEM;
        else if (req_ex)             s = STALL_EX;
        else if (req_id || req_if)   s = STALL_ID;
        else                         s = STALL_NONE;
        return s;
    endfunction

endpackage

// File: rtl/pipe_ctrl.sv
// Merges stage stall requests into the pipeline stall vector and turns MEM exceptions into a single flush.
// Exceptions raised during an in-flight bus access are held in PEND until the access completes.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
    parameter logic [15:0] WDOG_LIMIT = 16'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic [15:0] stall_cnt,
    output logic        stall_timeout
);

    state_e      state_q, state_d;
    logic [31:0] exc_q, exc_d;
    logic [31:0] epc_q, epc_d;
    logic [15:0] cnt_q, cnt_d;
    logic        tmo_q, tmo_d;

    logic [5:0]  stall_int;
    logic        flush_int;
    logic [31:0] new_pc_int;

    function automatic logic [31:0] redirect(input logic [31:0] code, input logic [31:0] epc);
        return (code == EXC_ERET) ? epc : EXC_VECTOR;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            exc_q   <= '0;
            epc_q   <= '0;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            exc_q   <= exc_d;
            epc_q   <= epc_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        exc_d   = exc_q;
        epc_d   = epc_q;
        unique case (state_q)
            ST_IDLE: begin
                if (excepttype_i != '0 && stallreq_mem) begin
                    state_d = ST_PEND;
                    exc_d   = excepttype_i;
                    epc_d   = cp0_epc_i;
                end
            end
            ST_PEND: begin
                if (!stallreq_mem) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        stall_int  = STALL_NONE;
        flush_int  = 1'b0;
        new_pc_int = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (excepttype_i != '0 && !stallreq_mem) begin
                    flush_int  = 1'b1;
                    new_pc_int = redirect(excepttype_i, cp0_epc_i);
                end else if (excepttype_i != '0) begin
                    stall_int = STALL_MEM;
                end else begin
                    stall_int = stall_merge(stallreq_if, stallreq_id, stallreq_ex, stallreq_mem);
                end
            end
            ST_PEND: begin
                if (stallreq_mem) begin
                    stall_int = STALL_MEM;
                end else begin
                    flush_int  = 1'b1;
                    new_pc_int = redirect(exc_q, epc_q);
                end
            end
            default: ;
        endcase
    end

    // Counter tracks the run of held cycles; a flush cycle breaks the run.
    always_comb begin
        cnt_d = '0;
        if (stall_int != STALL_NONE && !flush_int)
            cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        tmo_d = tmo_q | (cnt_q == WDOG_LIMIT);
    end

    assign stall         = rst ? STALL_NONE : stall_int;
    assign flush         = rst ? 1'b0       : flush_int;
    assign new_pc        = rst ? '0         : new_pc_int;
    assign stall_cnt     = rst ? '0         : cnt_q;
    assign stall_timeout = rst ? 1'b0       : tmo_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with hand-computed expectations; watchdog limit shrunk to 4.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic [31:0] excepttype_i, cp0_epc_i;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [15:0] stall_cnt;
    logic        stall_timeout;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.EXC_VECTOR(32'h0000_0020), .WDOG_LIMIT(16'd4)) dut (
        .clk(clk), .rst(rst),
        .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
        .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
        .excepttype_i(excepttype_i), .cp0_epc_i(cp0_epc_i),
        .stall(stall), .flush(flush), .new_pc(new_pc),
        .stall_cnt(stall_cnt), .stall_timeout(stall_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs are driven just after a rising edge; outputs are checked at the falling edge.
    task automatic drive(input logic r, input logic sif, input logic sid, input logic sex,
                         input logic smem, input logic [31:0] exc, input logic [31:0] epc);
        rst = r; stallreq_if = sif; stallreq_id = sid; stallreq_ex = sex;
        stallreq_mem = smem; excepttype_i = exc; cp0_epc_i = epc;
        @(negedge clk);
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic chk_out(input string tag, input logic [5:0] s, input logic f, input logic [31:0] pc);
        chk({tag, ".stall"}, {26'd0, stall}, {26'd0, s});
        chk({tag, ".flush"}, {31'd0, flush}, {31'd0, f});
        chk({tag, ".new_pc"}, new_pc, pc);
    endtask

    initial begin
        // reset: outputs forced low even with a bus request present
        drive(1, 0, 0, 0, 1, 32'h8, 32'h0);
        chk_out("rst", 6'b000000, 0, 0);
        chk("rst.cnt", {16'd0, stall_cnt}, 32'd0);
        chk("rst.tmo", {31'd0, stall_timeout}, 32'd0);
        next_cycle();

        // stall priority
        drive(0, 0, 1, 0, 0, 0, 0);  chk_out("prio_id", 6'b000111, 0, 0);   next_cycle();
        drive(0, 0, 1, 0, 1, 0, 0);  chk_out("prio_mem", 6'b011111, 0, 0);  next_cycle();
        drive(0, 0, 1, 1, 0, 0, 0);  chk_out("prio_ex", 6'b001111, 0, 0);   next_cycle();
        drive(0, 1, 0, 0, 0, 0, 0);  chk_out("prio_if", 6'b000111, 0, 0);   next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0);  chk_out("prio_none", 6'b000000, 0, 0); next_cycle();

        // syscall without bus: immediate flush, single pulse
        drive(0, 0, 0, 0, 0, 32'h8, 32'h4);  chk_out("sys", 6'b000000, 1, 32'h20);  next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0);          chk_out("sys_after", 6'b000000, 0, 0); next_cycle();

        // eret redirects to EPC
        drive(0, 0, 0, 0, 0, 32'he, 32'h1000); chk_out("eret", 6'b000000, 1, 32'h1000); next_cycle();

        // exception beats concurrent non-mem stall requests
        drive(0, 1, 1, 1, 0, 32'ha, 32'h0);    chk_out("exc_vs_stall", 6'b000000, 1, 32'h20); next_cycle();

        // pending overflow: held for 3 cycles, later eret on the input is ignored
        drive(0, 0, 0, 0, 1, 32'hc, 32'h0);    chk_out("pend1", 6'b011111, 0, 0); next_cycle();
        drive(0, 0, 0, 0, 1, 32'he, 32'h5000); chk_out("pend2", 6'b011111, 0, 0); next_cycle();
        drive(0, 0, 0, 0, 1, 32'h0, 32'h0);    chk_out("pend3", 6'b011111, 0, 0); next_cycle();
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0);    chk_out("pend_flush", 6'b000000, 1, 32'h20); next_cycle();
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0);    chk_out("pend_once", 6'b000000, 0, 0); next_cycle();

        // pending eret keeps captured EPC; fresh exception right after its flush
        drive(0, 0, 0, 0, 1, 32'he, 32'h2000); chk_out("pe1", 6'b011111, 0, 0); next_cycle();
        drive(0, 0, 0, 0, 0, 32'h8, 32'h9999); chk_out("pe_flush", 6'b000000, 1, 32'h2000); next_cycle();
        drive(0, 0, 0, 0, 0, 32'h1, 32'h0);    chk_out("fresh", 6'b000000, 1, 32'h20); next_cycle();

        // reset while pending discards the exception
        drive(0, 0, 0, 0, 1, 32'hd, 32'h0);    chk_out("rp_pend", 6'b011111, 0, 0); next_cycle();
        drive(1, 0, 0, 0, 1, 32'h0, 32'h0);    chk_out("rp_rst", 6'b000000, 0, 0); next_cycle();
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0);    chk_out("rp_after", 6'b000000, 0, 0); next_cycle();
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0);    chk_out("rp_after2", 6'b000000, 0, 0); next_cycle();

        // watchdog with limit 4
        for (int i = 0; i <= 5; i++) begin
            drive(0, 0, 0, 1, 0, 0, 0);
            chk($sformatf("wd_cnt%0d", i), {16'd0, stall_cnt}, i);
            chk($sformatf("wd_tmo%0d", i), {31'd0, stall_timeout}, (i >= 5) ? 32'd1 : 32'd0);
            next_cycle();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("wd_drop_cnt", {16'd0, stall_cnt}, 32'd6);
        chk("wd_drop_tmo", {31'd0, stall_timeout}, 32'd1);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("wd_clr_cnt", {16'd0, stall_cnt}, 32'd0);
        chk("wd_sticky", {31'd0, stall_timeout}, 32'd1);
        next_cycle();

        // flush cycle breaks a stall run
        drive(0, 0, 0, 1, 0, 0, 0);      next_cycle();
        drive(0, 0, 0, 1, 0, 0, 0);      chk("run_cnt", {16'd0, stall_cnt}, 32'd1); next_cycle();
        drive(0, 0, 0, 1, 0, 32'h8, 0);  chk_out("run_flush", 6'b000000, 1, 32'h20); next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0);      chk("run_cleared", {16'd0, stall_cnt}, 32'd0); next_cycle();

        // reset clears the sticky flag
        drive(1, 0, 0, 0, 0, 0, 0);      next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("tmo_rst", {31'd0, stall_timeout}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
